cb_muldiv: RTL
==============

Name: cb_muldiv

Overview:
Parametrised iterative multiply/divide unit. It executes the ISA's MULT/MULTI/DIV/DIVI operations in hardware, replacing the single-step behavioural arithmetic.
- Sits beside the ALU in the execute stage.
- The core stalls on busy and writes back result on done.
- Adds signed mode and divide-by-zero detection, which the previous behavioural model did not have.

Parameters:
WIDTH, 16, operand/result width in bits; must be >= 4.
CNT_W, $clog2(WIDTH)+1, iteration counter width; derived, not overridden.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  reset; asynchronous, active-high.
start  in  1  request; sampled only while in IDLE.
op  in  1  0 = multiply, 1 = divide.
sgn  in  1  1 = two's-complement operands, 0 = unsigned.
a  in  WIDTH  multiplicand / dividend.
b  in  WIDTH  multiplier / divisor.
busy  out  1  high from the accepting edge until the done cycle; the done cycle itself is not busy.
done  out  1  one-cycle pulse; result valid.
result  out  WIDTH  low product bits, or quotient.
dbz  out  1  divide-by-zero flag; valid with done.

Behaviour:
- Reset (async assert): state=IDLE; busy=0, done=0, result=0, dbz=0, counter=0; the optional rem output is also 0.
  - Release is synchronous to clk.
  - Reset mid-operation aborts with no done pulse.
- FSM states: IDLE, BUSY, FIX, DONE.
  - IDLE: start=1 at edge E0 captures a, b, op, sgn.
    - In signed mode, operands are converted to magnitudes and the result sign is recorded.
    - Multiply sign = sa^sb. Quotient sign = sa^sb. Remainder sign = sa.
    - Divide with b==0: go directly to DONE (done at E1, latency 1).
    - Otherwise go to BUSY, counter=0.
  - BUSY: one shift-add (multiply) or restoring shift-subtract (divide) step per edge; exactly WIDTH edges (E1..E_WIDTH). Then go to FIX.
  - FIX: apply the two's-complement sign correction. Go to DONE at E_WIDTH+1.
  - DONE: done=1 for exactly one cycle. Next edge returns to IDLE.
    - start is ignored in DONE; the new start is sampled in IDLE one cycle later.
- Latency, normal case: done asserted in the cycle after edge E_WIDTH+1, i.e. WIDTH+2 cycles after start is seen.
- start asserted in BUSY/FIX/DONE is ignored; operands are not re-captured.
- result and dbz hold their values from the done cycle until the next accepted start. They are cleared to 0 at that start's capture edge.
- Multiply:
  - 2*WIDTH-bit internal product; result = low WIDTH bits (truncation, wrap-around).
  - Signed and unsigned low halves are identical; sgn only affects the optional hi half.
- Divide:
  - Quotient truncates toward zero.
  - Remainder takes the sign of the dividend.
  - Signed overflow (most-negative / -1): result = most-negative value, dbz=0.
- Divide by zero: result = all ones, dbz=1; the optional rem output = a unmodified.
- dbz is 0 for every multiply.

Optional Feature:
CB_MULDIV_HI_EN
- Defined: adds output port hi (out, WIDTH).
  - Multiply: upper WIDTH bits of the full 2*WIDTH product, signed-correct when sgn=1.
  - Divide: remainder.
  - hi has the same reset, hold and clear rules as result.
- Undefined: port hi is absent; the upper product half and the remainder register are not built. Latency is unchanged.

Test Plan:
1. WIDTH=16, op=0, sgn=0, a=7, b=6, one-cycle start -> busy for 17 cycles; done pulse 18 cycles after start; result=0x002A, dbz=0, hi=0x0000.
2. op=0, sgn=1, a=0xFFFD (-3), b=5 -> result=0xFFF1, hi=0xFFFF. Repeat with sgn=0, a=0xFFFF, b=0xFFFF -> result=0x0001, hi=0xFFFE.
3. op=1, sgn=0, a=100, b=7 -> result=14, hi=2. Then sgn=1, a=0xFFF9 (-7), b=2 -> result=0xFFFD, hi=0xFFFF.
4. op=1, b=0, a=0x1234 -> done at the very next cycle; result=0xFFFF, dbz=1, hi=0x1234, busy stays 0. Then sgn=1, a=0x8000, b=0xFFFF -> result=0x8000, dbz=0.
5. Start 7*6; on cycle 5 pulse start with a=9, b=9 -> ignored; result=42 with a single done pulse. Back-to-back starts held high -> second operation accepted only in IDLE after DONE.
6. Assert rst asynchronously mid-BUSY (cycle 8) -> busy, done, result, dbz, hi go to 0 immediately; no done pulse. After release, 3*3 completes with result=9.

Source files
------------

// File: rtl/cb_muldiv.sv
// cb_muldiv: iterative multiply/divide, one shift-add or restoring shift-subtract step per cycle.
// Define CB_MULDIV_HI_EN to add output hi (upper product half, or remainder).
module cb_muldiv #(
  parameter int WIDTH = 16,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic             sgn,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             dbz
`ifdef CB_MULDIV_HI_EN
  ,
  output logic [WIDTH-1:0] hi
`endif
);
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_FIX, S_DONE} state_t;
  state_t r_state, w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [2*WIDTH-1:0] r_p;
  logic [WIDTH-1:0] r_d, r_res;
  logic r_op, r_neg, r_dbz;
  logic w_start, w_sa, w_sb, w_dbz;
  logic [WIDTH-1:0] w_ma, w_mb;
  logic [WIDTH:0] w_sum, w_trial;
  logic [2*WIDTH:0] w_sh;
  logic [2*WIDTH-1:0] w_mstep, w_dstep;
  assign w_start = (r_state == S_IDLE) && start;
  assign w_sa = sgn & a[WIDTH-1];
  assign w_sb = sgn & b[WIDTH-1];
  assign w_ma = w_sa ? -a : a;
  assign w_mb = w_sb ? -b : b;
  assign w_dbz = op & (b == '0);
  // r_p holds {partial product hi, multiplier} or {partial remainder, dividend/quotient}
  assign w_sum = {1'b0, r_p[2*WIDTH-1:WIDTH]} + (r_p[0] ? {1'b0, r_d} : '0);
  assign w_mstep = {w_sum, r_p[WIDTH-1:1]};
  assign w_sh = {r_p, 1'b0};
  assign w_trial = w_sh[2*WIDTH:WIDTH] - {1'b0, r_d};
  assign w_dstep = w_trial[WIDTH] ? w_sh[2*WIDTH-1:0] : {w_trial[WIDTH-1:0], w_sh[WIDTH-1:1], 1'b1};
  assign busy = (r_state == S_BUSY) || (r_state == S_FIX);
  assign done = r_state == S_DONE;
  assign result = r_res;
  assign dbz = r_dbz;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= S_IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = start ? (w_dbz ? S_DONE : S_BUSY) : S_IDLE;
      S_BUSY:  w_next = (r_cnt == CNT_W'(WIDTH - 1)) ? S_FIX : S_BUSY;
      S_FIX:   w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_p <= '0;
      r_d <= '0;
      r_op <= 1'b0;
      r_neg <= 1'b0;
      r_res <= '0;
      r_dbz <= 1'b0;
    end else if (w_start) begin
      r_cnt <= '0;
      r_p <= {{WIDTH{1'b0}}, w_ma};
      r_d <= w_mb;
      r_op <= op;
      r_neg <= w_sa ^ w_sb;
      r_res <= {WIDTH{w_dbz}};
      r_dbz <= w_dbz;
    end else if (r_state == S_BUSY) begin
      r_p <= r_op ? w_dstep : w_mstep;
      r_cnt <= r_cnt + 1'b1;
    end else if (r_state == S_FIX) begin
      r_res <= r_neg ? -r_p[WIDTH-1:0] : r_p[WIDTH-1:0];
    end
  end
`ifdef CB_MULDIV_HI_EN
  logic [WIDTH-1:0] r_hi;
  logic r_neg_hi;
  assign hi = r_hi;
  // negating the full product carries into the upper half only when the low half is zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hi <= '0;
      r_neg_hi <= 1'b0;
    end else if (w_start) begin
      r_hi <= w_dbz ? a : '0;
      r_neg_hi <= op ? w_sa : (w_sa ^ w_sb);
    end else if (r_state == S_FIX) begin
      r_hi <= r_neg_hi ? ~r_p[2*WIDTH-1:WIDTH] + WIDTH'(r_op | (r_p[WIDTH-1:0] == '0)) : r_p[2*WIDTH-1:WIDTH];
    end
  end
`endif
endmodule
